// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive definitions: frame geometry and receiver FSM state encodings.
package uart_rx_buffer_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int OVERSAMPLE     = 4;

   typedef logic [2:0] rx_state_t;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/generic_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write on collision).
module generic_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_rd_data <= '0;
      else if (rd_en) r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, x4-oversampled frame FSM and LSB-first shift register.
// state        | meaning
// ST_IDLE      | line idle, waiting for a low on rx_s
// ST_START     | confirming start bit at its midpoint
// ST_DATA      | sampling 8 data bits, one per 4 ticks
// ST_STOP      | sampling stop bit; good -> strobe byte, low -> frame error
// ST_WAIT_IDLE | after a bad stop, wait for the line to return high
module uart_rx_core
   import uart_rx_buffer_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      baud_x4,
   input  logic                      serial_rx,
   output logic [UART_DATA_BITS-1:0] rx_byte,
   output logic                      byte_strobe,
   output logic                      frame_err_pulse
);

   localparam logic [1:0] MID_START = 2'(OVERSAMPLE / 2 - 1);
   localparam logic [1:0] LAST_TICK = 2'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

   logic [SYNC_STAGES-1:0]    r_sync;
   logic                      w_rx_s;
   rx_state_t                 r_state;
   logic [1:0]                r_tick;
   logic [2:0]                r_bit;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      r_strobe;
   logic                      r_ferr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '1;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], serial_rx};
   end

   assign w_rx_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_tick   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
         if (baud_x4) begin
            r_tick <= r_tick + 2'd1;
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx_s) begin
                     r_state <= ST_START;
                     r_tick  <= '0;
                  end
               end
               ST_START: begin
                  if (r_tick == MID_START) begin
                     r_tick <= '0;
                     if (w_rx_s) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                     end
                  end
               end
               ST_DATA: begin
                  // tick counter wraps to 0 here, so the next bit is again 4 ticks away
                  if (r_tick == LAST_TICK) begin
                     r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                     r_bit   <= r_bit + 3'd1;
                     if (r_bit == LAST_BIT) r_state <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  if (r_tick == LAST_TICK) begin
                     if (w_rx_s) begin
                        r_strobe <= 1'b1;
                        r_state  <= ST_IDLE;
                     end else begin
                        r_ferr   <= 1'b1;
                        r_state  <= ST_WAIT_IDLE;
                     end
                  end
               end
               ST_WAIT_IDLE: begin
                  if (w_rx_s) r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign rx_byte         = r_shift;
   assign byte_strobe     = r_strobe;
   assign frame_err_pulse = r_ferr;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive path with RAM FIFO: received bytes are queued until popped by rd_strobe.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      baud_x4,
   input  logic                      serial_rx,
   input  logic                      rd_strobe,
   output logic [UART_DATA_BITS-1:0] rd_data,
   output logic                      rd_valid,
   output logic                      empty,
   output logic                      full,
   output logic [ADDR_WIDTH:0]       count,
   input  logic                      clear_errors,
   output logic                      overflow,
   output logic                      frame_err
);

   localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [UART_DATA_BITS-1:0] w_rx_byte;
   logic                      w_byte_strobe;
   logic                      w_frame_err_pulse;
   logic                      w_pop;
   logic                      w_push;
   logic                      w_drop;
   logic [ADDR_WIDTH:0]       w_count_nxt;

   logic [ADDR_WIDTH-1:0]     r_wptr;
   logic [ADDR_WIDTH-1:0]     r_rptr;
   logic [ADDR_WIDTH:0]       r_count;
   logic                      r_empty;
   logic                      r_full;
   logic                      r_rd_valid;
   logic                      r_overflow;
   logic                      r_frame_err;

   uart_rx_core #(.SYNC_STAGES(SYNC_STAGES)) u_core (
      .clk             (clk),
      .reset           (reset),
      .baud_x4         (baud_x4),
      .serial_rx       (serial_rx),
      .rx_byte         (w_rx_byte),
      .byte_strobe     (w_byte_strobe),
      .frame_err_pulse (w_frame_err_pulse)
   );

   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign w_pop  = rd_strobe & ~r_empty;
   assign w_push = w_byte_strobe & (~r_full | w_pop);
   assign w_drop = w_byte_strobe & r_full & ~w_pop;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CNT_ONE;
      else if (!w_push && w_pop) w_count_nxt = r_count - CNT_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         r_count    <= w_count_nxt;
         r_empty    <= (w_count_nxt == '0);
         r_full     <= (w_count_nxt == DEPTH);
         r_rd_valid <= w_pop;
         if (w_drop)            r_overflow <= 1'b1;
         else if (clear_errors) r_overflow <= 1'b0;
         if (w_frame_err_pulse) r_frame_err <= 1'b1;
         else if (clear_errors) r_frame_err <= 1'b0;
      end
   end

   generic_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(UART_DATA_BITS)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_push),
      .wr_addr (r_wptr),
      .wr_data (w_rx_byte),
      .rd_en   (w_pop),
      .rd_addr (r_rptr),
      .rd_data (rd_data)
   );

   assign rd_valid  = r_rd_valid;
   assign empty     = r_empty;
   assign full      = r_full;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule
